// File: rtl/tone_decoder.sv
// tone_decoder: measures the period of the left-channel tone pulled from the
// Audio_Controller read handshake, averages NUM_PER periods and matches the
// average against the 24 chromatic note periods (C3..B4) of the tone generator.
// TBL_SHIFT right-shifts the note table so a scaled-down tone set can be used;
// at its default of 0 the table holds the real CLOCK_50 periods.
module tone_decoder #(
    parameter logic signed [31:0] HYST       = 32'sd8388608,
    parameter logic [18:0]        MIN_PERIOD = 19'd50000,
    parameter logic [18:0]        MAX_PERIOD = 19'd524287,
    parameter int unsigned        NUM_PER    = 4,
    parameter int unsigned        TOL_SHIFT  = 6,
    parameter int unsigned        TBL_SHIFT  = 0
) (
    input  logic        CLOCK_50,
    input  logic        resetn,
    input  logic        audio_in_available,
    input  logic [31:0] left_channel_audio_in,
    output logic        read_audio_in,
    output logic [4:0]  note_idx,
    output logic        note_valid,
    output logic        note_strobe,
    output logic [18:0] period_avg
);

    localparam int unsigned NP_LOG = $clog2(NUM_PER);
    localparam int unsigned ACC_W  = 19 + NP_LOG;
    localparam int unsigned CNT_W  = NP_LOG + 1;

    typedef enum logic [1:0] {
        D_IDLE,
        D_SEARCH,
        D_DONE
    } state_t;

    state_t             state_q, state_d;
    logic               rd_q, rd_d;
    logic               hi_q, hi_d;
    logic [18:0]        cyc_q, cyc_d;
    logic               armed_q, armed_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [4:0]         idx_q, idx_d;
    logic [18:0]        best_diff_q, best_diff_d;
    logic [4:0]         best_idx_q, best_idx_d;
    logic [18:0]        period_avg_q, period_avg_d;
    logic [4:0]         note_idx_q, note_idx_d;
    logic               note_valid_q, note_valid_d;
    logic               strobe_q, strobe_d;

    logic signed [31:0] sample_s;
    logic               cap;
    logic               rise;
    logic               silent;
    logic               batch_done;
    logic [ACC_W-1:0]   acc_sum;
    logic [CNT_W-1:0]   cnt_inc;
    logic [18:0]        batch_avg;
    logic [18:0]        p_cur;
    logic [18:0]        diff;

    // Note periods in CLOCK_50 cycles: 2*(generator half-count+1).
    function automatic logic [18:0] period_of(input logic [4:0] i);
        logic [18:0] p;
        case (i)
            5'd0:    p = 19'd380162;
            5'd1:    p = 19'd360260;
            5'd2:    p = 19'd340138;
            5'd3:    p = 19'd320918;
            5'd4:    p = 19'd303032;
            5'd5:    p = 19'd286008;
            5'd6:    p = 19'd270272;
            5'd7:    p = 19'd255104;
            5'd8:    p = 19'd240964;
            5'd9:    p = 19'd227274;
            5'd10:   p = 19'd214582;
            5'd11:   p = 19'd202430;
            5'd12:   p = 19'd190478;
            5'd13:   p = 19'd180356;
            5'd14:   p = 19'd170942;
            5'd15:   p = 19'd160582;
            5'd16:   p = 19'd151518;
            5'd17:   p = 19'd143290;
            5'd18:   p = 19'd135136;
            5'd19:   p = 19'd127448;
            5'd20:   p = 19'd120482;
            5'd21:   p = 19'd113638;
            5'd22:   p = 19'd107198;
            5'd23:   p = 19'd101170;
            default: p = '0;
        endcase
        return p >> TBL_SHIFT;
    endfunction

    assign sample_s  = left_channel_audio_in;
    assign cap       = audio_in_available & ~rd_q;
    assign rise      = cap & ~hi_q & (sample_s > HYST);
    assign silent    = (cyc_q == MAX_PERIOD);
    assign acc_sum   = acc_q + ACC_W'(cyc_q);
    assign cnt_inc   = cnt_q + CNT_W'(1);
    assign batch_avg = 19'(acc_sum >> NP_LOG);
    assign p_cur     = period_of(idx_q);
    assign diff      = (period_avg_q >= p_cur) ? (period_avg_q - p_cur) : (p_cur - period_avg_q);

    // Handshake, Schmitt trigger, cycle counter and period accumulation.
    always_comb begin
        rd_d       = audio_in_available & ~rd_q;
        hi_d       = hi_q;
        cyc_d      = silent ? cyc_q : cyc_q + 19'd1;
        armed_d    = armed_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        batch_done = 1'b0;

        if (cap) begin
            if (!hi_q && (sample_s > HYST)) begin
                hi_d = 1'b1;
            end else if (hi_q && (sample_s < -HYST)) begin
                hi_d = 1'b0;
            end
        end

        if (silent) begin
            armed_d = 1'b0;
            acc_d   = '0;
            cnt_d   = '0;
        end

        if (rise) begin
            cyc_d = '0;
            // A rise landing on the saturated count is the first edge after silence.
            if (!armed_q || silent) begin
                armed_d = 1'b1;
                acc_d   = '0;
                cnt_d   = '0;
            end else if (cyc_q < MIN_PERIOD) begin
                acc_d = '0;
                cnt_d = '0;
            end else if (cnt_inc == CNT_W'(NUM_PER)) begin
                batch_done = 1'b1;
                acc_d      = '0;
                cnt_d      = '0;
            end else begin
                acc_d = acc_sum;
                cnt_d = cnt_inc;
            end
        end
    end

    // Decode FSM: linear nearest-period search over the table, then report.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        best_diff_d  = best_diff_q;
        best_idx_d   = best_idx_q;
        period_avg_d = period_avg_q;
        note_idx_d   = note_idx_q;
        note_valid_d = note_valid_q;
        strobe_d     = 1'b0;

        case (state_q)
            D_IDLE: begin
                if (batch_done) begin
                    period_avg_d = batch_avg;
                    idx_d        = '0;
                    state_d      = D_SEARCH;
                end
            end
            D_SEARCH: begin
                if ((idx_q == 5'd0) || (diff < best_diff_q)) begin
                    best_diff_d = diff;
                    best_idx_d  = idx_q;
                end
                if (idx_q == 5'd23) begin
                    state_d = D_DONE;
                end else begin
                    idx_d = idx_q + 5'd1;
                end
            end
            D_DONE: begin
                strobe_d = 1'b1;
                if (best_diff_q <= (period_avg_q >> TOL_SHIFT)) begin
                    note_idx_d   = best_idx_q;
                    note_valid_d = 1'b1;
                end else begin
                    note_valid_d = 1'b0;
                end
                state_d = D_IDLE;
            end
            default: state_d = D_IDLE;
        endcase

        if (silent) begin
            note_valid_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state_q      <= D_IDLE;
            rd_q         <= 1'b0;
            hi_q         <= 1'b0;
            cyc_q        <= '0;
            armed_q      <= 1'b0;
            acc_q        <= '0;
            cnt_q        <= '0;
            idx_q        <= '0;
            best_diff_q  <= '0;
            best_idx_q   <= '0;
            period_avg_q <= '0;
            note_idx_q   <= '0;
            note_valid_q <= 1'b0;
            strobe_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_q         <= rd_d;
            hi_q         <= hi_d;
            cyc_q        <= cyc_d;
            armed_q      <= armed_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            best_diff_q  <= best_diff_d;
            best_idx_q   <= best_idx_d;
            period_avg_q <= period_avg_d;
            note_idx_q   <= note_idx_d;
            note_valid_q <= note_valid_d;
            strobe_q     <= strobe_d;
        end
    end

    assign read_audio_in = rd_q;
    assign note_idx      = note_idx_q;
    assign note_valid    = note_valid_q;
    assign note_strobe   = strobe_q;
    assign period_avg    = period_avg_q;

endmodule
